// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared defaults and constants for the multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int CNT_W_DEF        = 27;
    localparam int DEFAULT_HALF_DEF = 50_000_000;   // 1 Hz output from 100 MHz
    localparam int HALF_DISABLE     = 0;

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/clk_div_channel.sv
// ============================================================================
// Module      : clk_div_channel
// Description : One divider channel: half-period counter, active/pending half
//               registers, toggle flop and (with TICK_OUT_EN) a rise tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
)(
    input  logic             clk_in,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    output logic             pend_busy,
    output logic             clk_out
`ifdef TICK_OUT_EN
    ,
    output logic             tick
`endif
);

    localparam logic [CNT_W-1:0] HALF_OFF = CNT_W'(HALF_DISABLE);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_clk;
    logic             w_running;
    logic             w_boundary;
    logic             w_stop_now;

    assign w_running  = (r_half != HALF_OFF);
    assign w_boundary = w_running && (r_cnt == (r_half - ONE));
    // A disable request while the output is low needs no phase to finish.
    assign w_stop_now = r_pend_valid && (r_pend == HALF_OFF) && !r_clk;

`ifdef TICK_OUT_EN
    logic r_tick;
    assign tick = r_tick;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_half       <= DEFAULT_HALF;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_clk        <= 1'b0;
`ifdef TICK_OUT_EN
            r_tick       <= 1'b0;
`endif
        end else begin
`ifdef TICK_OUT_EN
            r_tick <= 1'b0;
`endif
            // Accept only happens while nothing is pending, so it never
            // collides with the pending-clear below.
            if (wr_en) begin
                r_pend       <= wr_half;
                r_pend_valid <= 1'b1;
            end

            if (!w_running) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
                if (r_pend_valid) begin
                    r_half       <= r_pend;
                    r_pend_valid <= 1'b0;
                end
            end else if (w_stop_now) begin
                r_half       <= HALF_OFF;
                r_cnt        <= '0;
                r_pend_valid <= 1'b0;
            end else if (w_boundary) begin
                r_cnt <= '0;
                r_clk <= ~r_clk;
`ifdef TICK_OUT_EN
                r_tick <= ~r_clk;
`endif
                if (r_pend_valid) begin
                    r_half       <= r_pend;
                    r_pend_valid <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign pend_busy = r_pend_valid;
    assign clk_out   = r_clk;

endmodule : clk_div_channel

`default_nettype wire

// File: rtl/multi_clk_divider.sv
// ============================================================================
// Module      : multi_clk_divider
// Description : N-channel programmable square-wave clock divider with a
//               valid/ready config port. Optional macro TICK_OUT_EN adds a
//               per-channel rise tick output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF,
    parameter int CH_W         = 2
)(
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out
`ifdef TICK_OUT_EN
    ,
    output logic [NUM_CH-1:0] tick
`endif
);

    logic [31:0]       w_ch_idx;
    logic              w_ch_oor;
    logic              w_accept;
    logic [NUM_CH-1:0] w_pend_busy;
    logic [NUM_CH-1:0] w_wr_en;

    assign w_ch_idx = 32'(cfg_ch);
    assign w_ch_oor = (w_ch_idx >= 32'(NUM_CH));

    // Out-of-range targets have no pending slot, so they are always ready.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_idx == 32'(i)) begin
                cfg_ready = ~w_pend_busy[i];
            end
        end
    end

    assign w_accept = cfg_valid & cfg_ready;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_wr_en[g] = w_accept & (w_ch_idx == 32'(g));

            clk_div_channel #(
                .CNT_W        (CNT_W),
                .DEFAULT_HALF (CNT_W'(DEFAULT_HALF))
            ) u_channel (
                .clk_in    (clk_in),
                .reset     (reset),
                .wr_en     (w_wr_en[g]),
                .wr_half   (cfg_half),
                .pend_busy (w_pend_busy[g]),
                .clk_out   (clk_out[g])
`ifdef TICK_OUT_EN
                ,
                .tick      (tick[g])
`endif
            );
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= w_accept & w_ch_oor;
        end
    end

endmodule : multi_clk_divider

`default_nettype wire
